pkt_xmt_sched: RTL and testbench
================================

Name: pkt_xmt_sched

Overview:
Shares one serial packet link between NUM_REQ byte producers. Each packet is the 8-bit header HEAD followed by one body byte, sent MSB first, one bit per clock. This is the framing the team's serial-to-parallel receiver FSM decodes. The block arbitrates round-robin, serialises the winner's byte and enforces a minimum idle gap between packets. It is the transmit-side controller that feeds the receiver's data_in.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 1, extra idle (low) bits after each packet (0..15)
HEAD, 8'hA5, header byte prepended to every packet

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester send request; held with data until granted
data  input  NUM_REQ*8  byte for requester k is data[k*8+7:k*8]
grant  output  NUM_REQ  one-hot, 1-cycle pulse: winner's byte captured
busy  output  1  high from grant cycle through last gap cycle
src_id  output  $clog2(NUM_REQ)  index of current/last winner
data_out  output  1  serial line to receiver; 0 when idle
pkt_done  output  1  1-cycle pulse coincident with last packet bit

Behaviour:
- Reset state: grant=0, busy=0, src_id=0, data_out=0, pkt_done=0, FSM=IDLE, RR pointer=0 (requester 0 highest priority). All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE: data_out=0. On an edge where any req bit is high, the round-robin winner is chosen.
  - Winner = first set req at or after the pointer, wrapping.
  - Registered results: grant=onehot(winner), src_id=winner, shift register={HEAD,data[winner]}, bit count=0, busy=1, state->SEND, pointer->winner+1 mod NUM_REQ.
- SEND: data_out=shift MSB, so the first header bit appears in the same cycle grant is high. The register shifts each cycle, for exactly 16 cycles.
  - pkt_done=1 on bit 16.
  - Next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP: data_out=0 for GAP_CYCLES cycles, busy=1. Then IDLE with busy=0.
- Minimum low bits between packets = GAP_CYCLES+1 (the gap cycles plus one IDLE cycle). Back-to-back grants are spaced 17+GAP_CYCLES cycles apart.
- Handshake:
  - req and data are sampled only on the arbitration edge.
  - Dropping req before that edge withdraws the request with no grant.
  - req still high after grant is a new request.
  - req and data changes during SEND/GAP do not affect the packet in flight.
- Simultaneous requests: only one grant per arbitration. Losers keep req high and win in later rounds per pointer order.
- src_id holds its value after the packet until the next grant.
- Reset mid-packet aborts immediately: data_out=0, busy=0 from the next cycle, pointer=0. The partial packet is lost; the receiver resynchronises on the next header.

Optional Feature:
PKT_XMT_PARITY_EN
- Defined: one odd-parity bit (body bits plus parity have an odd count of ones) is sent after the body. The packet is 17 bits, pkt_done is on bit 17, and grant spacing is 18+GAP_CYCLES.
- Undefined: 16-bit packets with no parity logic.

Decomposition:
- Package ser_link_pkg holds:
  - constants HEAD_BYTE=8'hA5, HEAD_W=8, BODY_W=8, PKT_W (16, or 17 with parity)
  - typedef enum xmt_state_t {IDLE, SEND, GAP}
  - function odd_parity(byte)
- Sub-module rr_arbiter: req vector, pointer and advance strobe in; one-hot grant and index out. It is purely combinational except for the pointer register.

Test Plan:
- Reset, then req=4'b0100 with data[23:16]=8'h49 -> grant=4'b0100 for 1 cycle, src_id=2, data_out=1010_0101_0100_1001 over 16 cycles, pkt_done on the 16th, busy for 17 cycles (GAP_CYCLES=1).
- After reset, req=4'b1111 held -> grants in order 0,1,2,3, each 18 cycles after the previous; at least 2 low bits between packets.
- req0 and req3 held continuously -> grants alternate 0,3,0,3.
- Reset asserted on the 5th bit of a packet -> data_out=0 and busy=0 next cycle; req=4'b1010 then grants 1 first (pointer back to 0).
- req1 pulsed high, then dropped before the arbitration edge while another packet is in flight -> no grant to 1.
- Parity enabled: body 8'h49 sends parity bit 0; body 8'h56 sends parity 1; 17-bit packets, grant spacing 19.

Source files
------------

// File: rtl/pkt_xmt_sched_pkg.sv
// Shared constants, state type and parity helper for the serial packet link.
// PKT_W grows by one bit when PKT_XMT_PARITY_EN is defined.
package ser_link_pkg;

    localparam logic [7:0] HEAD_BYTE = 8'hA5;
    localparam int HEAD_W = 8;
    localparam int BODY_W = 8;
`ifdef PKT_XMT_PARITY_EN
    localparam int PKT_W = HEAD_W + BODY_W + 1;
`else
    localparam int PKT_W = HEAD_W + BODY_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } xmt_state_t;

    // Bit that makes body + parity hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/pkt_xmt_sched_if.sv
// Requester-side bundle of the packet transmit scheduler.
// master: requesters drive req/data; slave: scheduler drives grant/status/line.
interface pkt_xmt_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] data;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [IDX_W-1:0]     src_id;
    logic                 data_out;
    logic                 pkt_done;

    modport master (
        output req, data,
        input  grant, busy, src_id, data_out, pkt_done
    );

    modport slave (
        input  req, data,
        output grant, busy, src_id, data_out, pkt_done
    );

endinterface

// File: rtl/pkt_xmt_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick of first req at/after the pointer.
// Ports: clock, reset, req, adv (move pointer past winner), gnt one-hot, idx.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               k;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/pkt_xmt_sched.sv
// Round-robin serial packet scheduler: HEAD + body byte, MSB first, idle gap.
// Ports: clock, reset (sync, active high), bus (slave). Option: PKT_XMT_PARITY_EN.
module pkt_xmt_sched
    import ser_link_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         GAP_CYCLES = 1,
    parameter logic [7:0] HEAD       = HEAD_BYTE
) (
    input  logic           clock,
    input  logic           reset,
    pkt_xmt_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    xmt_state_t         state, state_nx;
    logic [4:0]         cnt;
    logic [PKT_W-1:0]   shreg;
    logic [NUM_REQ-1:0] arb_gnt, grant_q;
    logic [IDX_W-1:0]   arb_idx, src_q;
    logic               busy_q, done_q;
    logic               any_req, send_last, gap_last;
    logic               load, busy_d, done_d;
    logic [7:0]         sel_byte;
    logic [PKT_W-1:0]   pkt_word;

    assign any_req   = |bus.req;
    assign send_last = (state == SEND) && (cnt == 5'(PKT_W - 1));
    assign gap_last  = (state == GAP) && (cnt == 5'(GAP_CYCLES - 1));
    assign sel_byte  = bus.data[{arb_idx, 3'b000} +: 8];

`ifdef PKT_XMT_PARITY_EN
    assign pkt_word = {HEAD, sel_byte, odd_parity(sel_byte)};
`else
    assign pkt_word = {HEAD, sel_byte};
`endif

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clock(clock),
        .reset(reset),
        .req  (bus.req),
        .adv  (load),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any_req) state_nx = SEND;
            SEND: if (send_last) state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gap_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; pkt_done is set one edge early
    // so its register lines up with the final packet bit.
    always_comb begin
        load   = 1'b0;
        done_d = 1'b0;
        busy_d = (state_nx != IDLE);
        case (state)
            IDLE:    load   = any_req;
            SEND:    done_d = (cnt == 5'(PKT_W - 2));
            default: ;
        endcase
    end

    // The shift register zero-fills, so it is all zero once the packet is
    // out and its MSB doubles as the idle-low line.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
        end else begin
            grant_q <= load ? arb_gnt : '0;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load) src_q <= arb_idx;
            if (load) shreg <= pkt_word;
            else if (state == SEND) shreg <= shreg << 1;
            if (state == IDLE || state_nx != state) cnt <= '0;
            else cnt <= cnt + 5'd1;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.src_id   = src_q;
    assign bus.busy     = busy_q;
    assign bus.pkt_done = done_q;
    assign bus.data_out = shreg[PKT_W-1];

endmodule

// File: tb/tb_pkt_xmt_sched.sv
// Self-checking bench for pkt_xmt_sched: vector table, corner sequences,
// random traffic against a queue-based packet model.
module tb_pkt_xmt_sched;

    localparam int NR  = 4;
    localparam int GAP = 1;
`ifdef PKT_XMT_PARITY_EN
    localparam int PW = 17;
`else
    localparam int PW = 16;
`endif
    localparam int SPACING = PW + GAP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_xmt_sched_if #(.NUM_REQ(NR)) bus ();

    pkt_xmt_sched #(
        .NUM_REQ   (NR),
        .GAP_CYCLES(GAP),
        .HEAD      (8'hA5)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: each slot is one future line cycle {data_out, busy, pkt_done}.
    typedef struct packed {
        logic d;
        logic b;
        logic done;
    } slot_t;
    slot_t slots[$];
    int    m_ptr;
    logic [NR-1:0] m_grant;
    int    m_src;
    logic  m_dout, m_busy, m_done;

    int gq_idx[$];
    int gq_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] body;
        int w;
        slot_t s;
        m_grant = '0;
        if (rst) begin
            m_ptr = 0; slots.delete(); m_src = 0;
            m_dout = 0; m_busy = 0; m_done = 0;
            return;
        end
        if (slots.size() == 0 && bus.req != 0) begin
            w = -1;
            for (int i = 0; i < NR; i++)
                if (w < 0 && bus.req[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
            m_ptr = (w + 1) % NR;
            m_grant[w] = 1'b1;
            m_src = w;
            body = bus.data[w*8 +: 8];
            for (int i = 7; i >= 0; i--) slots.push_back('{8'hA5 >> i, 1'b1, 1'b0});
            for (int i = 7; i >= 0; i--) slots.push_back('{body[i], 1'b1, 1'b0});
            if (PW == 17) slots.push_back('{~^body, 1'b1, 1'b0});
            slots[slots.size()-1].done = 1'b1;
            for (int i = 0; i < GAP; i++) slots.push_back('{1'b0, 1'b1, 1'b0});
            slots.push_back('{1'b0, 1'b0, 1'b0});
        end
        if (slots.size() > 0) begin
            s = slots.pop_front();
            m_dout = s.d; m_busy = s.b; m_done = s.done;
        end else begin
            m_dout = 0; m_busy = 0; m_done = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("m_grant", int'(bus.grant), int'(m_grant));
        chk("m_src_id", int'(bus.src_id), m_src);
        chk("m_data_out", int'(bus.data_out), int'(m_dout));
        chk("m_busy", int'(bus.busy), int'(m_busy));
        chk("m_pkt_done", int'(bus.pkt_done), int'(m_done));
        for (int i = 0; i < NR; i++)
            if (bus.grant[i]) begin
                gq_idx.push_back(i);
                gq_cyc.push_back(cyc);
            end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (bus.grant != 0) begin
                ok = 1;
                return;
            end
        end
        errors++;
        checks++;
        $display("FAIL grant_timeout @cyc %0d: got none expected a grant", cyc);
    endtask

    typedef struct {
        logic [NR-1:0]   req;
        logic [NR*8-1:0] data;
        int              win;
        logic [7:0]      body;
    } vec_t;
    vec_t tbl[6];

    initial begin
        bit ok;
        logic [16:0] word;
        int n;

        bus.req  = '0;
        bus.data = '0;

        tbl[0] = '{4'b0100, 32'h0049_0000, 2, 8'h49};
        tbl[1] = '{4'b0001, 32'h0000_003C, 0, 8'h3C};
        tbl[2] = '{4'b1010, 32'h0000_5600, 1, 8'h56};
        tbl[3] = '{4'b1000, 32'hFF00_0000, 3, 8'hFF};
        tbl[4] = '{4'b1111, 32'h1234_5678, 0, 8'h78};
        tbl[5] = '{4'b0110, 32'h00AB_CD00, 1, 8'hCD};

        do_reset();
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_src_id", int'(bus.src_id), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_pkt_done", int'(bus.pkt_done), 0);

        foreach (tbl[v]) begin
            do_reset();
            bus.req  = tbl[v].req;
            bus.data = tbl[v].data;
            wait_grant(ok);
            bus.req = '0;
            if (ok) begin
                word = {8'hA5, tbl[v].body, ~^tbl[v].body};
                chk("vec_grant", int'(bus.grant), 1 << tbl[v].win);
                chk("vec_src_id", int'(bus.src_id), tbl[v].win);
                for (int b = 0; b < PW; b++) begin
                    if (b > 0) cycle();
                    if (b == 1) chk("vec_grant_pulse", int'(bus.grant), 0);
                    chk("vec_bit", int'(bus.data_out), int'(word[16-b]));
                    chk("vec_pkt_done", int'(bus.pkt_done), int'(b == PW - 1));
                    chk("vec_busy", int'(bus.busy), 1);
                end
                cycle();
                chk("vec_gap_busy", int'(bus.busy), 1);
                chk("vec_gap_low", int'(bus.data_out), 0);
                cycle();
                chk("vec_idle_busy", int'(bus.busy), 0);
                chk("vec_src_hold", int'(bus.src_id), tbl[v].win);
            end
        end

        // All four requesting: rotation 0,1,2,3 at fixed spacing.
        do_reset();
        gq_idx.delete(); gq_cyc.delete();
        bus.req = 4'b1111;
        bus.data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4 * SPACING + 4; i++) cycle();
        bus.req = '0;
        chk("rr4_count", (gq_idx.size() >= 4) ? 1 : 0, 1);
        n = (gq_idx.size() < 4) ? gq_idx.size() : 4;
        for (int i = 0; i < n; i++) chk("rr4_order", gq_idx[i], i);
        for (int i = 1; i < n; i++) chk("rr4_spacing", gq_cyc[i] - gq_cyc[i-1], SPACING);

        // Requesters 0 and 3 held: alternate.
        do_reset();
        gq_idx.delete(); gq_cyc.delete();
        bus.req = 4'b1001;
        for (int i = 0; i < 4 * SPACING + 4; i++) cycle();
        bus.req = '0;
        chk("alt_count", (gq_idx.size() >= 4) ? 1 : 0, 1);
        n = (gq_idx.size() < 4) ? gq_idx.size() : 4;
        for (int i = 0; i < n; i++) chk("alt_order", gq_idx[i], (i % 2) ? 3 : 0);

        // Reset on the 5th bit aborts, pointer back to 0.
        do_reset();
        bus.req = 4'b0100;
        bus.data = 32'h00FF_0000;
        wait_grant(ok);
        bus.req = '0;
        for (int i = 0; i < 4; i++) cycle();
        chk("abort_mid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        cycle();
        chk("abort_data_out", int'(bus.data_out), 0);
        chk("abort_busy", int'(bus.busy), 0);
        rst = 1'b0;
        bus.req = 4'b1010;
        wait_grant(ok);
        bus.req = '0;
        if (ok) chk("abort_regrant", int'(bus.src_id), 1);
        for (int i = 0; i < SPACING; i++) cycle();

        // Request 1 withdrawn while another packet is in flight.
        do_reset();
        gq_idx.delete(); gq_cyc.delete();
        bus.req = 4'b0001;
        wait_grant(ok);
        bus.req = '0;
        for (int i = 0; i < 3; i++) cycle();
        bus.req = 4'b0010;
        cycle();
        cycle();
        bus.req = '0;
        for (int i = 0; i < 2 * SPACING; i++) cycle();
        n = 0;
        foreach (gq_idx[i]) if (gq_idx[i] == 1) n++;
        chk("withdraw_no_grant1", n, 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = NR'($urandom_range(0, 15));
            bus.data = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
